// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: operation codes, FSM states and
// a small decode helper used by the top level.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_REM = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/execute_divider.sv
// Serial restoring divider: one trial subtract and shift per cycle, WIDTH
// iterations per divide, with a one-cycle done pulse at the end.
module execute_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;

  // The shifted partial remainder is below 2*divisor, so a borrow out of the
  // trial subtract means "divisor does not fit" and the remainder is restored.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q   <= '0;
        quo_q   <= dividend;
        dvsr_q  <= divisor;
        count_q <= CW'(WIDTH);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        if (!trial[WIDTH]) begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        count_q <= count_q - CW'(1);
        if (count_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/execute_unit.sv
// Handshaked execute stage: single-cycle ALU plus a serial divider, with a
// registered result and flags held until write-back consumes them.
module execute_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1_value,
  input  logic [WIDTH-1:0] src2_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_dbz
);

  import exec_pkg::*;

  state_e state, state_next;
  op_e    op_in;
  logic   accept;
  logic   div_op_in;
  logic   div_start;
  logic   load_now;
  logic   rem_sel;

  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_value;

  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic [WIDTH:0]     sum_wide;
  logic [2*WIDTH-1:0] product;

  assign op_in     = op_e'(op);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign div_op_in = is_div_op(op_in);
  // A divide by zero bypasses the divider and retires through the ALU path.
  assign div_start = accept && div_op_in && (src2_value != '0);
  assign load_now  = accept && !div_start;
  assign div_value = rem_sel ? div_rem : div_quo;

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    sum_wide   = '0;
    product    = '0;
    case (op_in)
      OP_ADD: begin
        sum_wide   = {1'b0, src1_value} + {1'b0, src2_value};
        alu_result = sum_wide[WIDTH-1:0];
        alu_carry  = sum_wide[WIDTH];
      end
      OP_SUB: begin
        sum_wide   = {1'b0, src1_value} - {1'b0, src2_value};
        alu_result = sum_wide[WIDTH-1:0];
        alu_carry  = sum_wide[WIDTH];
      end
      OP_MUL: begin
        product    = {{WIDTH{1'b0}}, src1_value} * {{WIDTH{1'b0}}, src2_value};
        alu_result = product[WIDTH-1:0];
        alu_carry  = |product[2*WIDTH-1:WIDTH];
      end
      OP_DIV:  alu_result = '1;
      OP_REM:  alu_result = src1_value;
      OP_AND:  alu_result = src1_value & src2_value;
      OP_OR:   alu_result = src1_value | src2_value;
      OP_XOR:  alu_result = src1_value ^ src2_value;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_next = div_start ? ST_DIV : ST_DONE;
        end else if ((state == ST_DONE) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_DIV: begin
        // Falling back to IDLE if the divider ever stops without a result
        // keeps the unit from waiting forever.
        if (div_done) begin
          state_next = ST_DONE;
        end else if (!div_busy) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_dbz   <= 1'b0;
      rem_sel    <= 1'b0;
    end else begin
      state <= state_next;
      if (div_start) begin
        rem_sel <= (op_in == OP_REM);
      end
      if (load_now) begin
        result     <= alu_result;
        flag_zero  <= (alu_result == '0);
        flag_carry <= alu_carry;
        flag_dbz   <= div_op_in;
      end else if ((state == ST_DIV) && div_done) begin
        result     <= div_value;
        flag_zero  <= (div_value == '0);
        flag_carry <= 1'b0;
        flag_dbz   <= 1'b0;
      end
    end
  end

  execute_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (src1_value),
    .divisor   (src2_value),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule
